// File: rtl/xs3_bcd_stream_conv.sv
// Multi-digit excess-3 <-> BCD stream converter, one digit per clock, valid/ready on both sides.
// Optional per-digit range check: define XS3_CONV_ERR_EN.
module xs3_bcd_stream_conv #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [4*DIGITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_data,
  output logic [DIGITS-1:0]   out_err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  work_data;
  logic [W-1:0]  next_data;
  logic          work_mode;
  logic [3:0]    cur_digit;
  logic [3:0]    res_digit;
  logic          accept;

`ifdef XS3_CONV_ERR_EN
  logic [DIGITS-1:0] work_err;
  logic [DIGITS-1:0] next_err;
  logic              digit_bad;
`endif

  // DONE can hand off directly to a new word when the result leaves in the same cycle.
  assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (CW'(i) == cnt) cur_digit = work_data[4*i +: 4];
    end
  end

  always_comb begin
    res_digit = work_mode ? (cur_digit + 4'd3) : (cur_digit - 4'd3);
`ifdef XS3_CONV_ERR_EN
    digit_bad = work_mode ? (cur_digit > 4'd9)
                          : ((cur_digit < 4'd3) || (cur_digit > 4'd12));
    if (digit_bad) res_digit = 4'hF;
`endif
  end

  always_comb begin
    next_data = work_data;
    for (int i = 0; i < DIGITS; i++) begin
      if (CW'(i) == cnt) next_data[4*i +: 4] = res_digit;
    end
  end

`ifdef XS3_CONV_ERR_EN
  always_comb begin
    next_err = work_err;
    for (int i = 0; i < DIGITS; i++) begin
      if (CW'(i) == cnt) next_err[i] = digit_bad;
    end
  end
`else
  assign out_err = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work_data <= '0;
      work_mode <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef XS3_CONV_ERR_EN
      work_err  <= '0;
      out_err   <= '0;
`endif
    end else begin
      if (accept) begin
        work_data <= in_data;
        work_mode <= in_mode;
        cnt       <= '0;
        state     <= CONV;
`ifdef XS3_CONV_ERR_EN
        work_err  <= '0;
`endif
      end
      case (state)
        IDLE: ;
        CONV: begin
          work_data <= next_data;
`ifdef XS3_CONV_ERR_EN
          work_err  <= next_err;
`endif
          if (cnt == LAST) begin
            out_data  <= next_data;
`ifdef XS3_CONV_ERR_EN
            out_err   <= next_err;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!in_valid) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xs3_bcd_stream_conv.sv
// Self-checking bench for xs3_bcd_stream_conv: directed words plus a per-cycle
// scoreboard fed by a digit-wise arithmetic model.
module tb_xs3_bcd_stream_conv;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [D-1:0] out_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;
  int n_out = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [D-1:0] err;
    int           due;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  xs3_bcd_stream_conv #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Each digit independently: code-3 or code+3 modulo 16, with optional range flag.
  function automatic void model(input logic [W-1:0] d, input logic m,
                                output logic [W-1:0] r, output logic [D-1:0] e);
    r = '0;
    e = '0;
    for (int i = 0; i < D; i++) begin
      int c;
      int v;
      c = int'(d[4*i +: 4]);
      v = m ? (c + 3) % 16 : (c + 13) % 16;
`ifdef XS3_CONV_ERR_EN
      if (m ? (c > 9) : ((c < 3) || (c > 12))) begin
        v    = 15;
        e[i] = 1'b1;
      end
`endif
      r[4*i +: 4] = 4'(v);
    end
  endfunction

  always @(negedge clk) begin : monitor
    bit           ev;
    bit           er;
    exp_t         e;
    logic [W-1:0] md;
    logic [D-1:0] me;
    n_cyc++;
    if (!rst_n) begin
      checkOutput("in_ready_during_reset", in_ready, 0);
      exp_q.delete();
    end else begin
      ev = (exp_q.size() > 0) && (n_cyc >= exp_q[0].due);
      er = (exp_q.size() == 0) || (ev && out_ready);
      checkOutput("out_valid", out_valid, ev);
      checkOutput("in_ready", in_ready, er);
      if (ev) begin
        checkOutput("out_data", out_data, exp_q[0].data);
        checkOutput("out_err", out_err, exp_q[0].err);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        model(in_data, in_mode, md, me);
        e.data = md;
        e.err  = me;
        e.due  = n_cyc + 1 + D;
        exp_q.push_back(e);
      end
    end
  end

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic m, input bit keep,
                               output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) checkOutput({name, "_timeout"}, out_valid, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int           waited;
    int           lat;
    int           start_out;
    int           acc[8];
    logic [W-1:0] d;
    logic         m;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_err", out_err, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    nextEdge();

    applyStimulus(16'h4C73, 1'b0, 1'b0, waited);
    waitResult("xs3_word", lat);
    checkOutput("xs3_latency", lat, 4);
    checkOutput("xs3_data", out_data, 16'h1940);
    checkOutput("xs3_err", out_err, 4'b0000);
    nextEdge();
    @(negedge clk);
    checkOutput("xs3_single_pulse", out_valid, 0);
    nextEdge();

    applyStimulus(16'h0925, 1'b1, 1'b0, waited);
    waitResult("bcd_word", lat);
    checkOutput("bcd_data", out_data, 16'h3C58);
    checkOutput("bcd_err", out_err, 4'b0000);
    nextEdge();

    applyStimulus(16'h3D30, 1'b0, 1'b0, waited);
    waitResult("invalid_word", lat);
`ifdef XS3_CONV_ERR_EN
    checkOutput("invalid_data", out_data, 16'h0F0F);
    checkOutput("invalid_err", out_err, 4'b0101);
`else
    checkOutput("invalid_data", out_data, 16'h0A0D);
    checkOutput("invalid_err", out_err, 4'b0000);
`endif
    nextEdge();

    out_ready = 1'b0;
    applyStimulus(16'h0925, 1'b1, 1'b0, waited);
    waitResult("stall_word", lat);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_data", out_data, 16'h3C58);
      checkOutput("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    nextEdge();
    out_ready = 1'b1;
    applyStimulus(16'h4C73, 1'b0, 1'b0, waited);
    checkOutput("handoff_no_wait", waited, 0);
    waitResult("handoff_word", lat);
    checkOutput("handoff_latency", lat, 4);
    checkOutput("handoff_data", out_data, 16'h1940);
    nextEdge();

    applyStimulus(16'h0925, 1'b1, 1'b0, waited);
    nextEdge();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_out_data", out_data, 0);
    checkOutput("abort_out_err", out_err, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("abort_no_result", out_valid, 0);
    end
    nextEdge();

    out_ready = 1'b1;
    start_out = n_out;
    for (int i = 0; i < 8; i++) begin
      m = 1'(i % 2);
      for (int j = 0; j < D; j++) begin
        d[4*j +: 4] = m ? 4'($urandom_range(0, 9)) : 4'($urandom_range(3, 12));
      end
      applyStimulus(d, m, 1'b1, waited);
      acc[i] = n_cyc;
      if (i > 0) checkOutput("stream_spacing", acc[i] - acc[i-1], D + 1);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
    checkOutput("stream_result_count", n_out - start_out, 8);
    checkOutput("stream_drained", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
